// File: rtl/eq_compare_arbiter.sv
// rtl/eq_compare_arbiter.sv - round-robin shared 32-bit equality comparator
//
// Purpose:
//   One equality comparator is shared by NUM_REQ requesters. A round-robin
//   arbiter picks one request per transaction. Its operands are latched in the
//   grant cycle and compared in a dedicated CMP cycle. The result is then held
//   in RESP until the consumer accepts it. Accepted equal results are counted
//   in a 16-bit wrapping counter.
//
// Ports:
//   clock        rising-edge clock
//   reset_n      synchronous active-low reset
//   req_valid    per-requester request
//   req_a/req_b  packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready    one-hot grant, combinational, only in IDLE
//   rsp_valid    result available (RESP)
//   rsp_ready    consumer accepts result
//   rsp_eq       1 when the granted operands were bitwise equal
//   rsp_id       requester index owning rsp_eq
//   busy         state != IDLE
//   match_count  accepted results with rsp_eq=1, wraps at 16 bits

module eq_compare_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_eq,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy,
  output logic [15:0]              match_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  id_r;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             eq_r;

  logic             gnt_found;
  logic [ID_W-1:0]  gnt_idx;
  logic [ID_W-1:0]  slot;
  logic [ID_W-1:0]  next_ptr;
  logic             cmp_eq;

  // Round-robin search: the first valid requester at or after rr_ptr,
  // wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    slot      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_found && req_valid[slot]) begin
        gnt_found = 1'b1;
        gnt_idx   = slot;
      end
    end
  end

  // Pointer moves to just past the winner so it has lowest priority next time.
  always_comb begin
    next_ptr = '0;
    if (gnt_idx != ID_W'(NUM_REQ - 1)) begin
      next_ptr = gnt_idx + ID_W'(1);
    end
  end

  // Grant is only offered in IDLE, and is forced low while reset is held.
  always_comb begin
    req_ready = '0;
    if (reset_n && (state == IDLE) && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign cmp_eq = (op_a == op_b);
  assign busy   = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      id_r        <= '0;
      op_a        <= '0;
      op_b        <= '0;
      eq_r        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_eq      <= 1'b0;
      rsp_id      <= '0;
      match_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            op_a   <= req_a[int'(gnt_idx)*WIDTH +: WIDTH];
            op_b   <= req_b[int'(gnt_idx)*WIDTH +: WIDTH];
            id_r   <= gnt_idx;
            rr_ptr <= next_ptr;
            state  <= CMP;
          end
        end
        CMP: begin
          // rsp_eq/rsp_id are separate registers so they keep the previous
          // response's values until this new response is presented.
          eq_r      <= cmp_eq;
          rsp_eq    <= cmp_eq;
          rsp_id    <= id_r;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
            if (eq_r) begin
              match_count <= match_count + 16'd1;
            end
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
